// File: rtl/constraint_sample_driver.sv
// constraint_sample_driver: LFSR-driven candidate generator for combinational
// constraint checkers. Only satisfying assignments are forwarded downstream.
module constraint_sample_driver #(
    parameter int VEC_W   = 224,
    parameter int CHK_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [CNT_W-1:0] max_attempts,
    output logic [VEC_W-1:0] cand_vec,
    input  logic             chk_sat,
    output logic [VEC_W-1:0] sample_vec,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] attempt_count
);
    localparam int WORDS = (VEC_W + 31) / 32;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LAT_W = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;
    localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_END   = LAT_W'(CHK_LAT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_CHECK = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Galois step for x^32+x^22+x^2+x+1, shifting right
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] shifted;
        shifted = {1'b0, cur[31:1]};
        return cur[0] ? (shifted ^ LFSR_MASK) : shifted;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur);
        return (cur == {CNT_W{1'b1}}) ? cur : cur + CNT_W'(1);
    endfunction

    state_t           state_r;
    logic [31:0]      lfsr_r;
    logic [IDX_W-1:0] word_idx_r;
    logic [LAT_W-1:0] lat_cnt_r;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] max_att_r;

    logic [31:0]      lfsr_next_s;
    logic [CNT_W-1:0] att_inc_s;
    logic             check_budget_s;
    logic             emit_budget_s;

    assign lfsr_next_s    = lfsr_step(lfsr_r);
    assign att_inc_s      = sat_inc(attempt_count);
    // A zero budget means the run may try forever
    assign check_budget_s = (max_att_r != {CNT_W{1'b0}}) && (att_inc_s == max_att_r);
    assign emit_budget_s  = (max_att_r != {CNT_W{1'b0}}) && (attempt_count == max_att_r);

    // Run-control FSM: candidate build, checker sampling and sample handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            lfsr_r        <= 32'h1;
            word_idx_r    <= {IDX_W{1'b0}};
            lat_cnt_r     <= {LAT_W{1'b0}};
            remaining_r   <= {CNT_W{1'b0}};
            max_att_r     <= {CNT_W{1'b0}};
            cand_vec      <= {VEC_W{1'b0}};
            sample_vec    <= {VEC_W{1'b0}};
            sample_valid  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            attempt_count <= {CNT_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        lfsr_r        <= (seed == 32'h0) ? 32'h1 : seed;
                        remaining_r   <= num_samples;
                        max_att_r     <= max_attempts;
                        attempt_count <= {CNT_W{1'b0}};
                        fail          <= 1'b0;
                        word_idx_r    <= {IDX_W{1'b0}};
                        if (num_samples == {CNT_W{1'b0}}) begin
                            state_r <= S_DONE;
                        end else begin
                            state_r <= S_GEN;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_GEN: begin
                    lfsr_r <= lfsr_next_s;
                    // Word k lands in bits [32k+31:32k]; bits past VEC_W are dropped
                    for (int b = 0; b < VEC_W; b++) begin
                        if (word_idx_r == IDX_W'(b / 32)) begin
                            cand_vec[b] <= lfsr_next_s[b % 32];
                        end
                    end
                    if (word_idx_r == LAST_WORD) begin
                        word_idx_r <= {IDX_W{1'b0}};
                        lat_cnt_r  <= {LAT_W{1'b0}};
                        state_r    <= S_CHECK;
                    end else begin
                        word_idx_r <= word_idx_r + IDX_W'(1);
                    end
                end
                S_CHECK: begin
                    if (lat_cnt_r != LAT_END) begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end else begin
                        attempt_count <= att_inc_s;
                        if (chk_sat) begin
                            sample_vec   <= cand_vec;
                            sample_valid <= 1'b1;
                            state_r      <= S_EMIT;
                        end else if (check_budget_s) begin
                            fail    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            state_r <= S_GEN;
                        end
                    end
                end
                S_EMIT: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        remaining_r  <= remaining_r - CNT_W'(1);
                        if (remaining_r == CNT_W'(1)) begin
                            busy    <= 1'b0;
                            state_r <= S_DONE;
                        end else if (emit_budget_s) begin
                            fail    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            state_r <= S_GEN;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_constraint_sample_driver.sv
// Randomized bench for constraint_sample_driver: a run-level reference model
// predicts accepted samples, attempt counts and fail for each run.
module tb_constraint_sample_driver;
    localparam int VW   = 32;
    localparam int VW_B = 48;
    localparam int LAT_B = 2;
    localparam int WORDS_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, chk_sat, sample_valid, sample_ready, busy, done, fail;
    logic [31:0] seed;
    logic [15:0] num_samples, max_attempts, attempt_count;
    logic [VW-1:0] cand_vec, sample_vec;
    int mode;

    logic        b_start, b_chk, b_valid, b_busy, b_done, b_fail;
    logic [31:0] b_seed;
    logic [15:0] b_num, b_max, b_att;
    logic [VW_B-1:0] b_cand, b_sample;

    constraint_sample_driver #(.VEC_W(VW), .CHK_LAT(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .num_samples(num_samples),
        .max_attempts(max_attempts), .cand_vec(cand_vec), .chk_sat(chk_sat),
        .sample_vec(sample_vec), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .done(done), .fail(fail), .attempt_count(attempt_count));

    constraint_sample_driver #(.VEC_W(VW_B), .CHK_LAT(LAT_B), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .seed(b_seed), .num_samples(b_num),
        .max_attempts(b_max), .cand_vec(b_cand), .chk_sat(b_chk),
        .sample_vec(b_sample), .sample_valid(b_valid), .sample_ready(1'b1),
        .busy(b_busy), .done(b_done), .fail(b_fail), .attempt_count(b_att));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    // Checker models: 0 always sat, 1 never, 2 odd candidates, 3 low two bits zero
    function automatic logic accepts(input int md, input logic [31:0] c);
        case (md)
            0: return 1'b1;
            1: return 1'b0;
            2: return c[0];
            default: return c[1:0] == 2'b00;
        endcase
    endfunction

    assign chk_sat = accepts(mode, cand_vec);
    assign b_chk   = b_cand[0];

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int exp_att;
    bit exp_fail;

    task automatic model_run(input logic [31:0] eff_seed, input int ns, input int ma, input int md);
        logic [31:0] l;
        l = eff_seed;
        exp_q.delete();
        exp_att  = 0;
        exp_fail = 1'b0;
        while (exp_q.size() < ns) begin
            l = lfsr_step(l);
            exp_att++;
            if (accepts(md, l)) exp_q.push_back(l);
            if (exp_q.size() < ns && ma != 0 && exp_att == ma) begin
                exp_fail = 1'b1;
                break;
            end
        end
    endtask

    task automatic run(input logic [31:0] dut_seed, input logic [31:0] mdl_seed, input int ns,
                       input int ma, input int md, input int rdy_pct, input bit stall10,
                       input string tag);
        int cyc, hold, done_cyc;
        bit prev_v, prev_r, finished;
        logic [31:0] prev_vec, prev_cand;
        logic [15:0] prev_att;
        model_run(mdl_seed, ns, ma, md);
        got_q.delete();
        mode = md; seed = dut_seed; num_samples = 16'(ns); max_attempts = 16'(ma);
        start = 1'b1; sample_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; hold = 0; done_cyc = 0; prev_v = 1'b0; prev_r = 1'b0; finished = 1'b0;
        prev_vec = '0; prev_cand = '0; prev_att = '0;
        while (!finished && cyc < 20000) begin
            if (prev_v && !prev_r) begin
                check({tag, " stall valid"}, 64'(sample_valid), 64'(1));
                check({tag, " stall vec"}, 64'(sample_vec), 64'(prev_vec));
                check({tag, " stall cand"}, 64'(cand_vec), 64'(prev_cand));
                check({tag, " stall att"}, 64'(attempt_count), 64'(prev_att));
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
                check({tag, " fail"}, 64'(fail), 64'(exp_fail));
                check({tag, " attempts"}, 64'(attempt_count), 64'(exp_att));
                check({tag, " busy at done"}, 64'(busy), 64'(0));
            end else begin
                if (sample_valid && !prev_v) hold = stall10 ? 10 : 0;
                if (sample_valid && hold > 0) begin
                    sample_ready = 1'b0;
                    hold--;
                end else begin
                    sample_ready = ($urandom_range(99) < rdy_pct);
                end
                if (sample_valid && sample_ready) got_q.push_back(sample_vec);
                prev_v = sample_valid; prev_r = sample_ready;
                prev_vec = sample_vec; prev_cand = cand_vec; prev_att = attempt_count;
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " finished"}, 64'(finished), 64'(1));
        sample_ready = 1'b0;
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done), 64'(0));
        check({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, " sample"}, 64'(got_q[i]), 64'(exp_q[i]));
        if (ns == 0) check({tag, " done latency"}, 64'(done_cyc), 64'(2));
    endtask

    initial begin
        int cnt;
        logic [31:0] rs, l, w1, w2;
        logic [47:0] c, exp_b[2], got_b[2];
        int a, a_tot, exp_t[2], got_t[2], nv, cyc;
        bit bprev, fin;

        rst = 1'b1; start = 1'b0; seed = '0; num_samples = '0; max_attempts = '0;
        sample_ready = 1'b0; mode = 0;
        b_start = 1'b0; b_seed = '0; b_num = '0; b_max = '0;
        repeat (3) @(negedge clk);
        check("reset cand", 64'(cand_vec), 64'(0));
        check("reset sample", 64'(sample_vec), 64'(0));
        check("reset flags", 64'({sample_valid, busy, done, fail}), 64'(0));
        check("reset att", 64'(attempt_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 64'(busy), 64'(0));

        run(32'h1, 32'h1, 3, 0, 0, 100, 1'b0, "basic");
        check("basic first", 64'((got_q.size() > 0) ? got_q[0] : 32'h0), 64'(32'h8020_0003));
        run(32'h1234_5678, 32'h1234_5678, 3, 5, 1, 100, 1'b0, "nosat");
        rs = $urandom;
        run(rs, (rs == 32'h0) ? 32'h1 : rs, 4, 0, 2, 100, 1'b0, "odd");
        for (int i = 0; i < got_q.size(); i++) check("odd bit0", 64'(got_q[i][0]), 64'(1));
        rs = $urandom | 32'h1;
        run(rs, rs, 3, 0, 0, 100, 1'b1, "stall");
        run(32'h0, 32'h1, 3, 0, 0, 100, 1'b0, "seed0");
        run($urandom | 32'h1, 32'h1, 0, 0, 0, 100, 1'b0, "zero");
        for (int k = 0; k < 8; k++) begin
            rs = $urandom | 32'h2;
            run(rs, rs, $urandom_range(5, 1), ($urandom_range(1) != 0) ? $urandom_range(30, 1) : 0,
                $urandom_range(3, 2), $urandom_range(100, 30), 1'($urandom_range(1)), "rand");
        end

        // Reset mid-run while in GEN, with a simultaneous start that must be ignored
        mode = 0; seed = 32'hCAFE_0001; num_samples = 16'd10; max_attempts = '0;
        start = 1'b1; sample_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(attempt_count == 16'd2 && !sample_valid && busy) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("rst reached gen", 64'(cnt < 50), 64'(1));
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("rst cand", 64'(cand_vec), 64'(0));
        check("rst sample", 64'(sample_vec), 64'(0));
        check("rst flags", 64'({sample_valid, busy, done, fail}), 64'(0));
        check("rst att", 64'(attempt_count), 64'(0));
        rst = 1'b0; start = 1'b0; sample_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post rst idle", 64'({busy, done, sample_valid}), 64'(0));
        end
        run(32'hCAFE_0001, 32'hCAFE_0001, 3, 0, 0, 100, 1'b0, "rerun");

        // Multi-word candidates with checker latency on the second instance
        b_seed = $urandom | 32'h4; b_num = 16'd2; b_max = '0;
        l = b_seed; a_tot = 0;
        for (int s = 0; s < 2; s++) begin
            a = 0;
            do begin
                w1 = lfsr_step(l); w2 = lfsr_step(w1); l = w2; a++;
                c = {w2[15:0], w1};
            end while (!c[0]);
            a_tot += a;
            exp_b[s] = c;
            exp_t[s] = ((s == 0) ? 1 : exp_t[0] + 1) + (WORDS_B + LAT_B + 1) * a;
        end
        got_b[0] = '0; got_b[1] = '0; got_t[0] = 0; got_t[1] = 0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 1; nv = 0; bprev = 1'b0; fin = 1'b0;
        while (!fin && cyc < 2000) begin
            if (b_valid && !bprev) begin
                if (nv < 2) begin
                    got_b[nv] = b_sample;
                    got_t[nv] = cyc;
                end
                nv++;
            end
            bprev = b_valid;
            if (b_done) fin = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("wide finished", 64'(fin), 64'(1));
        check("wide count", 64'(nv), 64'(2));
        for (int s = 0; s < 2; s++) begin
            check("wide sample", 64'(got_b[s]), 64'(exp_b[s]));
            check("wide timing", 64'(got_t[s]), 64'(exp_t[s]));
        end
        check("wide attempts", 64'(b_att), 64'(a_tot));
        check("wide fail", 64'(b_fail), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
